// File: rtl/kb_scr_port_if.sv
// kb_scr_port_if: CPU device-register side and Arduino pin side of the keyboard/screen port.
interface kb_scr_port_if;
    logic       kb_rd;
    logic       scr_wr;
    logic [7:0] scr_wdata;
    logic       csr_wr;
    logic       csr_sel;
    logic [7:0] csr_wdata;
    logic [7:0] kb_data_o;
    logic [7:0] csr_kb_o;
    logic [7:0] csr_scr_o;
    logic       kb_irq;
    logic       scr_irq;
    logic [7:0] ard_data_i;
    logic       ard_stb_i;
    logic       ard_ack_o;
    logic [7:0] ard_data_o;
    logic       ard_stb_o;
    logic       ard_ack_i;
    modport master (
        output kb_rd, scr_wr, scr_wdata, csr_wr, csr_sel, csr_wdata, ard_data_i, ard_stb_i, ard_ack_i,
        input  kb_data_o, csr_kb_o, csr_scr_o, kb_irq, scr_irq, ard_ack_o, ard_data_o, ard_stb_o
    );
    modport slave (
        input  kb_rd, scr_wr, scr_wdata, csr_wr, csr_sel, csr_wdata, ard_data_i, ard_stb_i, ard_ack_i,
        output kb_data_o, csr_kb_o, csr_scr_o, kb_irq, scr_irq, ard_ack_o, ard_data_o, ard_stb_o
    );
endinterface

// File: rtl/kb_scr_port.sv
// kb_scr_port: keyboard/screen device engine bridging CPU register accesses to an Arduino
// over two 8-bit 4-phase handshakes, with KB/SCR CSR status and interrupt requests.
module kb_scr_port #(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 50000
) (
    input logic         i_clk,
    input logic         i_rst,
    kb_scr_port_if.slave bus
);
    localparam logic       K_IDLE    = 1'b0;
    localparam logic       K_ACK     = 1'b1;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT_HI = 2'd1;
    localparam logic [1:0] S_WAIT_LO = 2'd2;

    logic [SYNC_STAGES-1:0] r_stb_sync, r_ack_sync;
    logic                   r_stb_prev;
    logic                   r_k_state, w_k_next;
    logic [1:0]             r_s_state, w_s_next;
    logic [15:0]            r_cnt;
    logic [7:0]             r_kb_data, r_ard_data;
    logic                   r_kb_ie, r_kb_ena, r_kb_dba, r_kb_of;
    logic                   r_scr_ie, r_scr_ena, r_scr_dba, r_scr_of;
    logic                   w_stb, w_ack, w_stb_rise, w_to, w_s_acc;
    logic                   w_k_latch, w_s_done, w_s_to, w_s_ovr, w_kb_w1c, w_scr_w1c;

    assign w_stb      = r_stb_sync[SYNC_STAGES-1];
    assign w_ack      = r_ack_sync[SYNC_STAGES-1];
    assign w_stb_rise = w_stb & ~r_stb_prev;
    assign w_to       = r_cnt == 16'(ACK_TIMEOUT - 1);
    assign w_s_acc    = (r_s_state == S_IDLE) & bus.scr_wr & r_scr_dba & r_scr_ena;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stb_sync <= '0;
            r_ack_sync <= '0;
            r_stb_prev <= 1'b0;
            r_k_state  <= K_IDLE;
            r_s_state  <= S_IDLE;
        end else begin
            r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], bus.ard_stb_i};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], bus.ard_ack_i};
            r_stb_prev <= w_stb;
            r_k_state  <= w_k_next;
            r_s_state  <= w_s_next;
        end
    end

    // a pending timeout only matters if the awaited ack edge has not arrived this cycle
    always_comb begin
        w_k_next = (r_k_state == K_IDLE) ? (w_stb_rise ? K_ACK : K_IDLE) : (w_stb ? K_ACK : K_IDLE);
        w_s_next = (r_s_state == S_IDLE)    ? (w_s_acc ? S_WAIT_HI : S_IDLE) :
                   (r_s_state == S_WAIT_HI) ? (w_ack ? S_WAIT_LO : (w_to ? S_IDLE : S_WAIT_HI)) :
                                              ((!w_ack || w_to) ? S_IDLE : S_WAIT_LO);
    end

    always_comb begin
        w_k_latch      = (r_k_state == K_IDLE) & w_stb_rise & r_kb_ena;
        w_s_done       = (r_s_state != S_IDLE) & (w_s_next == S_IDLE);
        w_s_to         = w_s_done & ((r_s_state == S_WAIT_HI) | w_ack);
        w_s_ovr        = bus.scr_wr & r_scr_ena & ~r_scr_dba;
        w_kb_w1c       = bus.csr_wr & ~bus.csr_sel & bus.csr_wdata[3];
        w_scr_w1c      = bus.csr_wr & bus.csr_sel & bus.csr_wdata[3];
        bus.kb_data_o  = r_kb_data;
        bus.csr_kb_o   = {3'b0, r_kb_ena, r_kb_of, r_kb_dba, 1'b0, r_kb_ie};
        bus.csr_scr_o  = {3'b0, r_scr_ena, r_scr_of, r_scr_dba, 1'b1, r_scr_ie};
        bus.kb_irq     = r_kb_ie & r_kb_dba;
        bus.scr_irq    = r_scr_ie & r_scr_dba;
        bus.ard_ack_o  = r_k_state == K_ACK;
        bus.ard_stb_o  = r_s_state == S_WAIT_HI;
        bus.ard_data_o = r_ard_data;
    end

    // a byte latch outranks a coincident kb_rd: data stays flagged, overrun is forgotten
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_kb_data  <= 8'h00;
            r_ard_data <= 8'h00;
            r_cnt      <= 16'h0000;
            r_kb_ie    <= 1'b0;
            r_kb_ena   <= 1'b1;
            r_kb_dba   <= 1'b0;
            r_kb_of    <= 1'b0;
            r_scr_ie   <= 1'b0;
            r_scr_ena  <= 1'b1;
            r_scr_dba  <= 1'b1;
            r_scr_of   <= 1'b0;
        end else begin
            if (bus.csr_wr && !bus.csr_sel) {r_kb_ena, r_kb_ie} <= {bus.csr_wdata[4], bus.csr_wdata[0]};
            if (bus.csr_wr && bus.csr_sel) {r_scr_ena, r_scr_ie} <= {bus.csr_wdata[4], bus.csr_wdata[0]};
            if (w_k_latch) r_kb_data <= bus.ard_data_i;
            if (w_s_acc) r_ard_data <= bus.scr_wdata;
            r_kb_dba  <= w_k_latch | (r_kb_dba & ~bus.kb_rd);
            r_kb_of   <= ~bus.kb_rd & (w_k_latch ? (r_kb_of | r_kb_dba) : (r_kb_of & ~w_kb_w1c));
            r_scr_dba <= ~w_s_acc & (r_scr_dba | w_s_done);
            r_scr_of  <= w_s_to | w_s_ovr | (r_scr_of & ~w_scr_w1c);
            r_cnt     <= (w_s_next != r_s_state || r_s_state == S_IDLE) ? 16'h0000 : r_cnt + 16'h0001;
        end
    end
endmodule

// File: tb/tb_kb_scr_port.sv
// tb_kb_scr_port: vector table for the keyboard path, directed sequences for the screen path,
// and a scoreboard checking the byte seen at each ack/strobe rise.
module tb_kb_scr_port;
    localparam int SYNC = 2;
    localparam int TMO  = 8;

    typedef struct {
        logic [7:0] data;
        logic       rd;
        logic       ena;
        logic [7:0] exp_kb;
        logic [7:0] exp_csr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   kb_q[$];
    int   scr_q[$];
    logic prev_ack = 1'b0;
    logic prev_stb = 1'b0;
    vec_t tbl[6];

    kb_scr_port_if bus();
    kb_scr_port #(.SYNC_STAGES(SYNC), .ACK_TIMEOUT(TMO)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (bus.ard_ack_o && !prev_ack) begin
            if (kb_q.size() == 0) check("kb_sb_empty", 32'(kb_q.size()), 1);
            else check("kb_data_sb", 32'(bus.kb_data_o), 32'(kb_q.pop_front()));
        end
        if (bus.ard_stb_o && !prev_stb) begin
            if (scr_q.size() == 0) check("scr_sb_empty", 32'(scr_q.size()), 1);
            else check("ard_data_sb", 32'(bus.ard_data_o), 32'(scr_q.pop_front()));
        end
        prev_ack = bus.ard_ack_o;
        prev_stb = bus.ard_stb_o;
    end

    task automatic csr_write(input logic sel, input logic [7:0] d);
        bus.csr_wr = 1'b1; bus.csr_sel = sel; bus.csr_wdata = d;
        @(negedge clk);
        bus.csr_wr = 1'b0;
    endtask

    task automatic kb_read();
        bus.kb_rd = 1'b1;
        @(negedge clk);
        bus.kb_rd = 1'b0;
    endtask

    task automatic kb_send(input logic [7:0] b, input logic [7:0] exp);
        int n;
        kb_q.push_back(int'(exp));
        bus.ard_data_i = b; bus.ard_stb_i = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!bus.ard_ack_o && n < 40);
        check("ack_rise_lat", 32'(n), 32'(SYNC + 1));
        bus.ard_stb_i = 1'b0; bus.ard_data_i = 8'hEE; n = 0;
        do begin @(negedge clk); n++; end while (bus.ard_ack_o && n < 40);
        check("ack_fall_lat", 32'(n), 32'(SYNC + 1));
    endtask

    initial begin
        int n;
        tbl[0] = '{8'h41, 1'b0, 1'b1, 8'h41, 8'h14};
        tbl[1] = '{8'h42, 1'b0, 1'b1, 8'h42, 8'h1C};
        tbl[2] = '{8'h43, 1'b1, 1'b1, 8'h43, 8'h14};
        tbl[3] = '{8'h66, 1'b1, 1'b0, 8'h43, 8'h00};
        tbl[4] = '{8'h41, 1'b0, 1'b1, 8'h41, 8'h14};
        tbl[5] = '{8'h42, 1'b0, 1'b1, 8'h42, 8'h1C};
        bus.kb_rd = 1'b0; bus.scr_wr = 1'b0; bus.scr_wdata = 8'h00;
        bus.csr_wr = 1'b0; bus.csr_sel = 1'b0; bus.csr_wdata = 8'h00;
        bus.ard_data_i = 8'h00; bus.ard_stb_i = 1'b0; bus.ard_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_csr_kb", 32'(bus.csr_kb_o), 32'h10);
        check("rst_csr_scr", 32'(bus.csr_scr_o), 32'h16);
        check("rst_kb_data", 32'(bus.kb_data_o), 32'h00);
        check("rst_stb_ack", 32'({bus.ard_stb_o, bus.ard_ack_o}), 32'h0);

        for (int i = 0; i < 6; i++) begin
            csr_write(1'b0, tbl[i].ena ? 8'h10 : 8'h00);
            if (tbl[i].rd) kb_read();
            kb_send(tbl[i].data, tbl[i].exp_kb);
            check("tbl_kb_data", 32'(bus.kb_data_o), 32'(tbl[i].exp_kb));
            check("tbl_csr_kb", 32'(bus.csr_kb_o), 32'(tbl[i].exp_csr));
        end
        check("kb_irq_off", 32'(bus.kb_irq), 32'h0);
        csr_write(1'b0, 8'h11);
        check("kb_ie_csr", 32'(bus.csr_kb_o), 32'h1D);
        check("kb_irq_on", 32'(bus.kb_irq), 32'h1);
        csr_write(1'b0, 8'h10);
        check("kb_ie_clr", 32'(bus.csr_kb_o), 32'h1C);

        // byte 0x33 latches on the same edge as kb_rd
        kb_q.push_back(32'h33);
        bus.ard_data_i = 8'h33; bus.ard_stb_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.kb_rd = 1'b1;
        @(negedge clk);
        bus.kb_rd = 1'b0;
        check("coinc_ack", 32'(bus.ard_ack_o), 32'h1);
        check("coinc_data", 32'(bus.kb_data_o), 32'h33);
        check("coinc_csr", 32'(bus.csr_kb_o), 32'h14);
        bus.ard_stb_i = 1'b0; n = 0;
        while (bus.ard_ack_o && n < 20) begin @(negedge clk); n++; end
        check("coinc_ack_fall", 32'(bus.ard_ack_o), 32'h0);
        kb_read();
        check("kb_rd_clr", 32'(bus.csr_kb_o), 32'h10);
        check("kb_w1c_noop", 32'(bus.kb_data_o), 32'h33);

        csr_write(1'b1, 8'h11);
        check("scr_irq_on", 32'(bus.scr_irq), 32'h1);
        csr_write(1'b1, 8'h10);
        check("scr_irq_off", 32'(bus.scr_irq), 32'h0);

        // screen write acked by the Arduino, with a busy write in between
        scr_q.push_back(32'h5A);
        bus.scr_wr = 1'b1; bus.scr_wdata = 8'h5A;
        @(negedge clk);
        bus.scr_wdata = 8'h77;
        check("scr_stb_hi", 32'(bus.ard_stb_o), 32'h1);
        check("scr_busy_csr", 32'(bus.csr_scr_o), 32'h12);
        @(negedge clk);
        bus.scr_wr = 1'b0; bus.ard_ack_i = 1'b1;
        check("scr_ovr_csr", 32'(bus.csr_scr_o), 32'h1A);
        check("scr_data_kept", 32'(bus.ard_data_o), 32'h5A);
        check("scr_stb_wait", 32'(bus.ard_stb_o), 32'h1);
        n = 0;
        while (bus.ard_stb_o && n < 20) begin @(negedge clk); n++; end
        check("scr_stb_fall", 32'(bus.ard_stb_o), 32'h0);
        check("scr_dba_wait_lo", 32'(bus.csr_scr_o[2]), 32'h0);
        bus.ard_ack_i = 1'b0; n = 0;
        while (!bus.csr_scr_o[2] && n < 20) begin @(negedge clk); n++; end
        check("scr_done_csr", 32'(bus.csr_scr_o), 32'h1E);
        check("scr_data_hold", 32'(bus.ard_data_o), 32'h5A);
        csr_write(1'b1, 8'h18);
        check("scr_of_w1c", 32'(bus.csr_scr_o), 32'h16);

        // no ack: strobe must drop after TMO cycles
        scr_q.push_back(32'h99);
        bus.scr_wr = 1'b1; bus.scr_wdata = 8'h99;
        @(negedge clk);
        bus.scr_wr = 1'b0; n = 0;
        while (bus.ard_stb_o && n < 30) begin n++; @(negedge clk); end
        check("tmo_stb_cycles", 32'(n), 32'(TMO));
        check("tmo_csr", 32'(bus.csr_scr_o), 32'h1E);
        csr_write(1'b1, 8'h18);
        check("tmo_of_w1c", 32'(bus.csr_scr_o), 32'h16);

        // reset in the middle of S_WAIT_HI
        scr_q.push_back(32'hC3);
        bus.scr_wr = 1'b1; bus.scr_wdata = 8'hC3;
        @(negedge clk);
        bus.scr_wr = 1'b0;
        check("prerst_stb", 32'(bus.ard_stb_o), 32'h1);
        rst = 1'b1;
        #1;
        check("rst_stb_async", 32'(bus.ard_stb_o), 32'h0);
        check("rst_kb_data_async", 32'(bus.kb_data_o), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_csr_scr", 32'(bus.csr_scr_o), 32'h16);
        check("postrst_csr_kb", 32'(bus.csr_kb_o), 32'h10);
        check("postrst_ard_data", 32'(bus.ard_data_o), 32'h00);
        check("kb_q_left", 32'(kb_q.size()), 32'h0);
        check("scr_q_left", 32'(scr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
